ntt_bram_responder: RTL and testbench

- Synthesizable PL-side responder for the NTT core's BRAM port-B master interface. It replaces the Zynq block-design memory and host for standalone simulation and bring-up.
- Owns an 8192x64 memory that answers the NTT core's BRAM accesses.
- Sequences the NTT core through one run:
  - holds the core in reset while coefficients are loaded over a host stream;
  - releases reset and waits for the core's done signal;
  - streams the result memory back to the host.

---
 rtl/ntt_bram_responder.sv | 216 +++++++++++++++++++++
 tb/tb_ntt_bram_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bram_responder.sv
// Standalone memory/host stand-in for the NTT core's BRAM port-B master: loads coefficients,
// runs the core once, then streams the result memory back out.
module ntt_bram_responder #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned N_WORDS = 8192,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              err_timeout,
  output logic              ntt_rst,
  input  logic              ntt_done,
  input  logic [ADDR_W-1:0] BRAM_addr,
  input  logic [DATA_W-1:0] BRAM_din,
  output logic [DATA_W-1:0] BRAM_dout,
  input  logic              BRAM_en,
  input  logic              BRAM_we,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned RunW  = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] NWords  = CntW'(N_WORDS);
  localparam logic [CntW-1:0] LastIdx = CntW'(N_WORDS - 1);
  localparam logic [RunW-1:0] RunMax  = RunW'(TIMEOUT);
  localparam logic [RunW-1:0] RunLast = RunW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StOut
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   load_cnt_q, load_cnt_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [RunW-1:0]   run_cnt_q, run_cnt_d;
  logic              err_q, err_d;

  // Readback pipeline: stage 1 is the memory read register, stage 2 the output register.
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] bram_dout_q;

  logic [DATA_W-1:0] mem [Depth];

  logic load_fire;
  logic ntt_access;
  logic ntt_write;
  logic s2_ready;
  logic s1_adv;
  logic rd_issue;
  logic out_fire;

  always_comb begin
    load_fire  = (state_q == StLoad) && in_valid && !rst;
    ntt_access = (state_q == StRun) && BRAM_en && !rst;
    ntt_write  = ntt_access && BRAM_we;
    s2_ready   = !out_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_ready;
    rd_issue   = (state_q == StOut) && s1_adv && (rd_cnt_q < NWords);
    out_fire   = out_valid_q && out_ready;
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    run_cnt_d   = run_cnt_q;
    err_d       = err_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          load_cnt_d = '0;
          rd_cnt_d   = '0;
          run_cnt_d  = '0;
          err_d      = 1'b0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          load_cnt_d = load_cnt_q + CntW'(1);
          if (load_cnt_q == LastIdx) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (run_cnt_q != RunMax) begin
          run_cnt_d = run_cnt_q + RunW'(1);
        end
        // Done wins over a timeout landing on the same cycle.
        if (ntt_done) begin
          state_d = StDrain;
        end else if (run_cnt_q == RunLast) begin
          err_d   = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d     = StOut;
        rd_cnt_d    = '0;
        s1_valid_d  = 1'b0;
        s1_last_d   = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      StOut: begin
        if (s2_ready) begin
          out_valid_d = s1_valid_q;
          out_last_d  = s1_valid_q && s1_last_q;
          if (s1_valid_q) begin
            out_data_d = rd_data_q;
          end
        end
        if (s1_adv) begin
          s1_valid_d = rd_issue;
          s1_last_d  = (rd_cnt_q == LastIdx);
        end
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + CntW'(1);
        end
        if (out_fire && out_last_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      load_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      run_cnt_q   <= '0;
      err_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      run_cnt_q   <= run_cnt_d;
      err_q       <= err_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Host and NTT ports never write in the same state, so one write path per port suffices.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[load_cnt_q[ADDR_W-1:0]] <= in_data;
    end
    if (ntt_write) begin
      mem[BRAM_addr] <= BRAM_din;
    end
    if (rd_issue) begin
      rd_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
    end
  end

  // Read-first: a write cycle returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_dout_q <= '0;
    end else if (ntt_access) begin
      bram_dout_q <= mem[BRAM_addr];
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    ntt_rst     = (state_q != StRun);
    in_ready    = (state_q == StLoad);
    err_timeout = err_q;
    BRAM_dout   = bram_dout_q;
    out_data    = out_data_q;
    out_valid   = out_valid_q;
    out_last    = out_last_q;
  end

endmodule

// File: tb/tb_ntt_bram_responder.sv
// Bench for ntt_bram_responder: directed port-timing table, timeout, resets and randomized
// backpressure runs checked against an array model of the memory contents.
module tb_ntt_bram_responder;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned NW = 16;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          err_timeout;
  logic          ntt_rst;
  logic          ntt_done;
  logic [AW-1:0] BRAM_addr;
  logic [DW-1:0] BRAM_din;
  logic [DW-1:0] BRAM_dout;
  logic          BRAM_en;
  logic          BRAM_we;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  int total = 0;
  int bad   = 0;
  int low_cnt = 0;

  logic [DW-1:0] ld    [NW];
  logic [DW-1:0] model [NW];

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
  } port_vec_t;

  port_vec_t vecs [9];

  ntt_bram_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .N_WORDS(NW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .err_timeout(err_timeout),
    .ntt_rst    (ntt_rst),
    .ntt_done   (ntt_done),
    .BRAM_addr  (BRAM_addr),
    .BRAM_din   (BRAM_din),
    .BRAM_dout  (BRAM_dout),
    .BRAM_en    (BRAM_en),
    .BRAM_we    (BRAM_we),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Observed length of the window during which the core is out of reset.
  always @(negedge clk) if (!ntt_rst) low_cnt++;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_seq(input logic [DW-1:0] base);
    for (int i = 0; i < NW; i++) begin
      ld[i]    = base + DW'(i);
      model[i] = ld[i];
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NW; i++) begin
      ld[i]    = {$urandom, $urandom};
      model[i] = ld[i];
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
  endtask

  task automatic load_words(input int max_words, input bit rnd, input bit junk);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < max_words && cyc < 3000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = ld[i];
      if (junk) begin
        BRAM_en   = 1'b1;
        BRAM_we   = 1'b1;
        BRAM_addr = AW'(i);
        BRAM_din  = 64'hBAD0_BAD0;
      end
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    BRAM_en  = 1'b0;
    BRAM_we  = 1'b0;
    if (i < max_words) chk("load_timeout", 64'(i), 64'(max_words));
  endtask

  task automatic wait_run();
    int g = 0;
    while (!ntt_rst && g < 300) begin
      tick();
      g++;
    end
    if (!ntt_rst) chk("run_exit_timeout", ntt_rst, 1);
  endtask

  task automatic read_out(input int max_beats, input bit rnd, input bit chk_first);
    int            i = 0;
    int            cyc = 0;
    int            first = -1;
    bit            stalled = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;
    while (i < max_beats && cyc < 3000) begin
      if (out_valid && first < 0) first = cyc;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = {$urandom, $urandom};
      if (!rnd) chk("out_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("rd_data", out_data, model[i]);
        chk("rd_last", out_last, (i == NW - 1) ? 1 : 0);
        i++;
      end
      stalled = out_valid && !out_ready;
      pd      = out_data;
      pl      = out_last;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (i < max_beats) chk("rd_timeout", 64'(i), 64'(max_beats));
    if (chk_first) chk("first_valid_by_3", (first >= 0 && first <= 3) ? 1 : 0, 1);
    if (max_beats == NW) begin
      chk("idle_after_out", busy, 0);
      chk("no_extra_beat", out_valid, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ntt_rst"}, ntt_rst, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  // Loads 0x1000+i with the core idle (done tied high) and reads it back.
  task automatic run_basic(input bit chk_dout_zero);
    fill_seq(64'h1000);
    ntt_done = 1'b1;
    do_start();
    low_cnt = 0;
    load_words(NW, 1'b0, 1'b1);
    chk("basic_ntt_rst_low", ntt_rst, 0);
    wait_run();
    chk("basic_run_len", 64'(low_cnt), 1);
    read_out(NW, 1'b0, 1'b1);
    chk("basic_err", err_timeout, 0);
    if (chk_dout_zero) chk("basic_dout_untouched", BRAM_dout, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd5,  64'h0,    64'h1005};
    vecs[1] = '{1'b1, 1'b1, 4'd5,  64'hDEAD, 64'h1005};
    vecs[2] = '{1'b1, 1'b0, 4'd5,  64'h0,    64'hDEAD};
    vecs[3] = '{1'b0, 1'b0, 4'd2,  64'h0,    64'hDEAD};
    vecs[4] = '{1'b0, 1'b1, 4'd2,  64'h1234, 64'hDEAD};
    vecs[5] = '{1'b1, 1'b0, 4'd2,  64'h0,    64'h1002};
    vecs[6] = '{1'b1, 1'b1, 4'd15, 64'hBEEF, 64'h100F};
    vecs[7] = '{1'b1, 1'b0, 4'd15, 64'h0,    64'hBEEF};
    vecs[8] = '{1'b1, 1'b0, 4'd0,  64'h0,    64'h1000};

    rst = 1'b1; start = 1'b0; ntt_done = 1'b0;
    BRAM_addr = '0; BRAM_din = '0; BRAM_en = 1'b0; BRAM_we = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    chk("reset_err", err_timeout, 0);
    chk("reset_dout", BRAM_dout, 0);
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Load/readback with master accesses attempted outside RUN.
    run_basic(1'b1);

    // Core multiplies every word by 3, done after 50 RUN cycles; start held during LOAD.
    fill_seq(64'h1000);
    for (int i = 0; i < NW; i++) model[i] = ld[i] * 3;
    ntt_done = 1'b0;
    do_start();
    low_cnt = 0;
    start = 1'b1;
    load_words(NW, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      BRAM_en = 1'b1; BRAM_we = 1'b0; BRAM_addr = AW'(i);
      tick();
      chk("ntt_rd", BRAM_dout, ld[i]);
      BRAM_we = 1'b1; BRAM_din = BRAM_dout * 3;
      tick();
    end
    BRAM_en = 1'b0; BRAM_we = 1'b0;
    repeat (50 - 2 * NW) tick();
    ntt_done = 1'b1;
    tick();
    ntt_done = 1'b0;
    chk("mul_drain_ntt_rst", ntt_rst, 1);
    chk("mul_run_len", 64'(low_cnt), 51);
    read_out(NW, 1'b0, 1'b1);
    chk("mul_err", err_timeout, 0);

    // Port timing table.
    fill_seq(64'h1000);
    do_start();
    load_words(NW, 1'b0, 1'b0);
    for (int v = 0; v < 9; v++) begin
      BRAM_en = vecs[v].en; BRAM_we = vecs[v].we;
      BRAM_addr = vecs[v].addr; BRAM_din = vecs[v].din;
      tick();
      chk($sformatf("port_vec%0d", v), BRAM_dout, vecs[v].exp_dout);
      if (vecs[v].en && vecs[v].we) model[vecs[v].addr] = vecs[v].din;
    end
    BRAM_en = 1'b0; BRAM_we = 1'b0;
    ntt_done = 1'b1;
    tick();
    ntt_done = 1'b0;
    read_out(NW, 1'b0, 1'b1);

    // Timeout: done never asserts.
    fill_rand();
    do_start();
    low_cnt = 0;
    load_words(NW, 1'b0, 1'b0);
    chk("to_err_early", err_timeout, 0);
    wait_run();
    chk("to_run_len", 64'(low_cnt), TO);
    chk("to_err_set", err_timeout, 1);
    read_out(NW, 1'b1, 1'b1);
    chk("to_err_sticky", err_timeout, 1);
    fill_rand();
    ntt_done = 1'b1;
    do_start();
    chk("to_err_cleared", err_timeout, 0);
    load_words(NW, 1'b1, 1'b0);
    wait_run();
    read_out(NW, 1'b1, 1'b0);

    // Randomized backpressure on both streams: 512 runs of 16 words.
    for (int r = 0; r < 512; r++) begin
      fill_rand();
      do_start();
      load_words(NW, 1'b1, 1'b0);
      wait_run();
      read_out(NW, 1'b1, 1'b0);
    end

    // Reset while loading word 7.
    fill_seq(64'h2000);
    do_start();
    load_words(7, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_reset_outputs("rst_load");
    run_basic(1'b0);

    // Reset after three readback beats.
    do_start();
    load_words(NW, 1'b0, 1'b0);
    wait_run();
    read_out(3, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_out");
    run_basic(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
